// File: rtl/muldiv_ctrl_if.sv
// Handshake and data bundle between the Execute stage and the mul/div sequencer.
interface muldiv_ctrl_if;
    logic        start;
    logic [2:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        flush;
    logic        stall;
    logic        done;
    logic [31:0] result;
    logic        busy;

    modport master (output start, op, src_a, src_b, flush,
                    input  stall, done, result, busy);
    modport slave  (input  start, op, src_a, src_b, flush,
                    output stall, done, result, busy);
endinterface

// File: rtl/muldiv_ctrl.sv
// Multi-cycle multiply/divide sequencer: 2-cycle multiply, 32-step restoring divide,
// sign fix-up, and a pipeline stall held until the result is registered.
module muldiv_ctrl (
    input  logic           clk,
    input  logic           rst,
    muldiv_ctrl_if.slave   bus
);
    typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

    state_t      state_q, state_d;
    logic [2:0]  op_q, op_d;
    logic [31:0] a_q, a_d, b_q, b_d;
    logic [31:0] q_q, q_d, r_q, r_d, d_q, d_d;
    logic [31:0] result_q, result_d;
    logic [63:0] prod_q, prod_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        dz_q, dz_d;

    function automatic logic [31:0] neg32(input logic [31:0] x);
        return ~x + 32'd1;
    endfunction

    function automatic logic [31:0] mag32(input logic [31:0] x, input logic is_signed);
        return (is_signed && x[31]) ? neg32(x) : x;
    endfunction

    logic signed [63:0] prod_s;
    logic        [63:0] prod_u;
    logic        [63:0] prod_sel;
    logic        [32:0] shift_r;
    logic        [33:0] trial;
    logic               div_signed;
    logic        [31:0] q_fix, r_fix;

    assign prod_s   = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
    assign prod_u   = {32'd0, a_q} * {32'd0, b_q};
    assign prod_sel = (op_q == 3'b010) ? prod_u : prod_s;

    // Restoring step: remainder is always < divisor, so 2r+1 fits in 33 bits.
    assign shift_r = {r_q, q_q[31]};
    assign trial   = {1'b0, shift_r} - {2'b00, d_q};

    assign div_signed = ~op_q[1];
    assign q_fix = dz_q ? 32'hFFFF_FFFF :
                   (div_signed && (a_q[31] ^ b_q[31])) ? neg32(q_q) : q_q;
    assign r_fix = dz_q ? a_q : (div_signed && a_q[31]) ? neg32(r_q) : r_q;

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        q_d      = q_q;
        r_d      = r_q;
        d_d      = d_q;
        result_d = result_q;
        prod_d   = prod_q;
        cnt_d    = cnt_q;
        dz_d     = dz_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    op_d = bus.op;
                    a_d  = bus.src_a;
                    b_d  = bus.src_b;
                    dz_d = 1'b0;
                    if (!bus.op[2]) begin
                        state_d = S_MUL;
                    end else if (bus.src_b == 32'd0) begin
                        state_d = S_FIX;
                        dz_d    = 1'b1;
                    end else begin
                        state_d = S_DIV;
                        cnt_d   = 5'd31;
                        r_d     = 32'd0;
                        q_d     = mag32(bus.src_a, ~bus.op[1]);
                        d_d     = mag32(bus.src_b, ~bus.op[1]);
                    end
                end
            end
            S_MUL: begin
                prod_d   = prod_sel;
                result_d = (op_q == 3'b001 || op_q == 3'b010) ? prod_sel[63:32] : prod_sel[31:0];
                state_d  = S_DONE;
            end
            S_DIV: begin
                if (!trial[33]) begin
                    r_d = trial[31:0];
                    q_d = {q_q[30:0], 1'b1};
                end else begin
                    r_d = shift_r[31:0];
                    q_d = {q_q[30:0], 1'b0};
                end
                if (cnt_q == 5'd0) begin
                    state_d = S_FIX;
                end else begin
                    cnt_d = cnt_q - 5'd1;
                end
            end
            S_FIX: begin
                q_d      = q_fix;
                r_d      = r_fix;
                result_d = op_q[0] ? r_fix : q_fix;
                state_d  = S_DONE;
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // A flushed op must leave no trace on the architectural result.
        if (bus.flush) begin
            state_d  = S_IDLE;
            result_d = result_q;
            op_d     = op_q;
            a_d      = a_q;
            b_d      = b_q;
            dz_d     = dz_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            op_q     <= 3'd0;
            a_q      <= 32'd0;
            b_q      <= 32'd0;
            q_q      <= 32'd0;
            r_q      <= 32'd0;
            d_q      <= 32'd0;
            result_q <= 32'd0;
            prod_q   <= 64'd0;
            cnt_q    <= 5'd0;
            dz_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            q_q      <= q_d;
            r_q      <= r_d;
            d_q      <= d_d;
            result_q <= result_d;
            prod_q   <= prod_d;
            cnt_q    <= cnt_d;
            dz_q     <= dz_d;
        end
    end

    assign bus.stall  = ~bus.flush & ~rst &
                        (((state_q == S_IDLE) & bus.start) | (state_q == S_MUL) |
                         (state_q == S_DIV) | (state_q == S_FIX));
    assign bus.done   = (state_q == S_DONE) & ~bus.flush;
    assign bus.busy   = (state_q != S_IDLE);
    assign bus.result = result_q;
endmodule

// File: doc/muldiv_ctrl.md
# muldiv_ctrl

Multi-cycle multiply/divide sequencer for the Execute stage. Accepts one LoongArch MUL/MULH/MULHU/DIV/MOD/DIVU/MODU operation per request, runs a 2-cycle multiply or a 32-iteration restoring divide, and holds the pipeline with `stall` until the result is ready. `flush` cancels an in-flight operation. The block owns the iterative divider datapath and the product register; the ALU path is separate.

## Interface
- No parameters; data width is fixed at 32.
- `clk` in 1: the single clock.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: EX holds a valid mul/div op; stays high while stalled.
- `op` in 3: 000 MUL, 001 MULH, 010 MULHU, 100 DIV, 101 MOD, 110 DIVU, 111 MODU. Codes 011 and 1xx are as listed; 011 is treated as MUL.
- `src_a` in 32: rj operand (dividend / multiplicand).
- `src_b` in 32: rk operand (divisor / multiplier).
- `flush` in 1: cancels the current op; synchronous.
- `stall` out 1: freezes IF..EX; combinational.
- `done` out 1: 1-cycle pulse; `result` is valid.
- `result` out 32: op result; held until the next accepted start.
- `busy` out 1: state != IDLE.

## Operation
- The state machine has five states: IDLE, MUL, DIV, FIX, DONE.
- IDLE, on `start & !flush`:
  - Latch `op`, `src_a` and `src_b`.
  - op[2]=0: go to MUL.
  - op[2]=1 and `src_b`==0: go to FIX, with div-by-zero flagged.
  - Otherwise: go to DIV, loading `cnt`=31. The remainder register is cleared. The quotient register is loaded with |a| (signed ops) or a (unsigned ops). The divisor register is loaded with |b| or b.
- MUL:
  - Compute the 64-bit product into the product register.
  - Signed×signed for MUL/MULH; unsigned×unsigned for MULHU.
  - Next state is DONE.
- DIV, one restoring step per cycle:
  - `{r,q} <<= 1`, then trial = r − d (33-bit).
  - If trial is non-negative, r = trial and q[0] = 1.
  - Decrement `cnt`; at `cnt`==0, go to FIX.
- FIX:
  - Signed ops: negate q if sign(a)^sign(b); negate r if sign(a).
  - Div-by-zero: q = 0xFFFFFFFF, r = a.
  - Next state is DONE.
- DONE:
  - Register the selected result: MUL uses the low 32 bits of the product, MULH/MULHU the high 32, DIV/DIVU uses q, MOD/MODU uses r.
  - `done`=1, then return to IDLE. `start` is ignored in this cycle because it is the same instruction.
- Overflow: 0x80000000 DIV 0xFFFFFFFF gives q=0x80000000 and r=0 (natural wrap, no trap).
- `stall` = !`flush` & !`rst` & ((IDLE & `start`) | MUL | DIV | FIX).
- `flush` in any state: next state is IDLE, no `done`, `result` unchanged. A flush in the same cycle as a start means the start is not accepted.
- `rst` mid-operation: immediate return to IDLE.

## Timing
- Reset values:
  - state = IDLE
  - `result` = 0
  - `done` = 0
  - `busy` = 0
  - `cnt` = 0
  - internal q/r/d/product registers = 0
  - `stall` = 0 while `rst` is high
- Cycle 0 is the first cycle with `start` high in IDLE. `stall` is 1 from cycle 0.
- Multiply: MUL in cycle 1, DONE in cycle 2. `done`=1 and `stall`=0 in cycle 2; the pipeline advances at the end of cycle 2.
- Divide: DIV in cycles 1..32, FIX in cycle 33, DONE in cycle 34.
- Divide by zero: FIX in cycle 1, DONE in cycle 2.
- `result` is registered on entry to DONE, so it is valid in the DONE cycle and held afterwards.
- Back-to-back operations: a new `start` in the cycle after DONE is accepted immediately (IDLE).
- `busy`=1 in MUL, DIV, FIX and DONE.

## Test plan
- MUL with a=0xFFFFFFFF (−1), b=3 → `done` in cycle 2, `result`=0xFFFFFFFD; `stall`=1 in cycles 0–1 and 0 in cycle 2.
- MULH with a=0x80000000, b=2 → 0xFFFFFFFF. MULHU with the same operands → 0x00000001.
- DIV with a=−7, b=2 → q=0xFFFFFFFD (−3). MOD with the same operands → 0xFFFFFFFF (−1). DIVU with a=100, b=7 → 14. `done` in cycle 34.
- DIVU with b=0, a=0x1234 → q=0xFFFFFFFF. MODU with the same operands → 0x1234. `done` in cycle 2. DIV with a=0x80000000, b=−1 → 0x80000000.
- `flush` asserted in cycle 10 of a DIV → IDLE in cycle 11, no `done`, `result` keeps its previous value. A new MUL started in cycle 11 completes normally.
- `rst` asserted mid-DIV → `stall`, `busy` and `done` all 0 immediately, `result`=0. Two back-to-back MULs → `done` pulses in cycles 2 and 5.
